// File: rtl/isa_cycle_sequencer.sv
// isa_cycle_sequencer: turns a decoded Zorro-II bus cycle into a timed ISA cycle (BALE, command strobe, SA0, XRDYD, buffer enables).
// Latency: BALE one cycle after the synchronised start, strobe BALE_CYC later, XRDYD after CMD_MIN strobe cycles; all outputs registered.
// Backpressure: ISA WAIT low stretches the strobe; XRDYD holds until AS rises. ISA_WAIT_TIMEOUT_EN adds a WAIT timeout with berr_req.
module isa_cycle_sequencer #(
    parameter int BALE_CYC    = 1,
    parameter int CMD_MIN     = 4,
    parameter int RECOV_CYC   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic mclk,
    input  logic reset,
    input  logic AS,
    input  logic UDS,
    input  logic LDS,
    input  logic RW,
    input  logic mem_sel,
    input  logic io_sel,
    input  logic WAIT,
    output logic BALE,
    output logic MEMR,
    output logic MEMW,
    output logic IOR,
    output logic IOW,
    output logic SA0,
    output logic XRDYD,
    output logic dg_oe,
    output logic da_oe,
    output logic berr_req
);

    localparam int M1      = (BALE_CYC > CMD_MIN) ? BALE_CYC : CMD_MIN;
    localparam int M2      = (M1 > RECOV_CYC) ? M1 : RECOV_CYC;
    localparam int CNT_MAX = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ALE_LAST = CNT_W'(BALE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_MIN - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_CMD,
        S_WAITST,
        S_DONE,
        S_RECOVER
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             is_mem, is_mem_nxt;
    logic             is_rd, is_rd_nxt;
    logic             sa0_q, sa0_nxt;
    logic [1:0]       as_sr, uds_sr, lds_sr, wait_sr;
    logic             as_s, uds_s, lds_s, wait_s;
    logic             start;
    logic             berr_nxt;
    logic             strobe_on;
    logic             bale_d, memr_d, memw_d, ior_d, iow_d, xrdyd_d, dg_d, da_d;
`ifdef ISA_WAIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic timeout_hit;
    logic berr_q;
`endif

    // Strobes idle high, so the synchronisers reset to the inactive level.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            as_sr   <= 2'b11;
            uds_sr  <= 2'b11;
            lds_sr  <= 2'b11;
            wait_sr <= 2'b11;
        end else begin
            as_sr   <= {as_sr[0], AS};
            uds_sr  <= {uds_sr[0], UDS};
            lds_sr  <= {lds_sr[0], LDS};
            wait_sr <= {wait_sr[0], WAIT};
        end
    end

    assign as_s   = as_sr[1];
    assign uds_s  = uds_sr[1];
    assign lds_s  = lds_sr[1];
    assign wait_s = wait_sr[1];

    // Writes only start once a data strobe is seen, which covers DS lagging AS.
    assign start = !as_s && (!uds_s || !lds_s) && (mem_sel ^ io_sel);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        is_mem_nxt = is_mem;
        is_rd_nxt  = is_rd;
        sa0_nxt    = sa0_q;
`ifdef ISA_WAIT_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_ALE;
                    cnt_nxt    = '0;
                    is_mem_nxt = mem_sel;
                    is_rd_nxt  = RW;
                    sa0_nxt    = !lds_s && uds_s;
                end
            end
            S_ALE: begin
                if (cnt == ALE_LAST) begin
                    state_nxt = S_CMD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CMD: begin
                // An early AS negation is only honoured once CMD_MIN is met.
                if (cnt == CMD_LAST) begin
                    cnt_nxt = '0;
                    if (as_s)
                        state_nxt = S_RECOVER;
                    else if (!wait_s)
                        state_nxt = S_WAITST;
                    else
                        state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAITST: begin
                if (wait_s) begin
                    state_nxt = S_DONE;
                end else if (as_s) begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = '0;
                end
`ifdef ISA_WAIT_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_nxt   = S_DONE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (as_s) begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = '0;
                end
            end
            S_RECOVER: begin
                // A start seen here is picked up from IDLE once recovery ends.
                if (cnt == REC_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_mem <= 1'b0;
            is_rd  <= 1'b0;
            sa0_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            is_mem <= is_mem_nxt;
            is_rd  <= is_rd_nxt;
            sa0_q  <= sa0_nxt;
        end
    end

`ifdef ISA_WAIT_TIMEOUT_EN
    assign berr_nxt = timeout_hit || (berr_q && (state_nxt == S_DONE));

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset)
            berr_q <= 1'b0;
        else
            berr_q <= berr_nxt;
    end

    assign berr_req = berr_q;
`else
    assign berr_nxt = 1'b0;
    assign berr_req = 1'b0;
`endif

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        strobe_on = state_nxt inside {S_CMD, S_WAITST, S_DONE};
        bale_d    = (state_nxt == S_ALE);
        memr_d    = !(strobe_on && is_mem_nxt && is_rd_nxt);
        memw_d    = !(strobe_on && is_mem_nxt && !is_rd_nxt);
        ior_d     = !(strobe_on && !is_mem_nxt && is_rd_nxt);
        iow_d     = !(strobe_on && !is_mem_nxt && !is_rd_nxt);
        xrdyd_d   = !((state_nxt == S_DONE) && !berr_nxt);
        dg_d      = !is_rd_nxt && (state_nxt inside {S_ALE, S_CMD, S_WAITST, S_DONE});
        da_d      = is_rd_nxt && (state_nxt == S_DONE);
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            BALE  <= 1'b0;
            MEMR  <= 1'b1;
            MEMW  <= 1'b1;
            IOR   <= 1'b1;
            IOW   <= 1'b1;
            SA0   <= 1'b0;
            XRDYD <= 1'b1;
            dg_oe <= 1'b0;
            da_oe <= 1'b0;
        end else begin
            BALE  <= bale_d;
            MEMR  <= memr_d;
            MEMW  <= memw_d;
            IOR   <= ior_d;
            IOW   <= iow_d;
            SA0   <= sa0_nxt;
            XRDYD <= xrdyd_d;
            dg_oe <= dg_d;
            da_oe <= da_d;
        end
    end

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Bench for isa_cycle_sequencer: randomized Amiga cycles, expected ISA cycle shape queued per cycle and checked by a monitor.
module tb_isa_cycle_sequencer;

    localparam int BC = 1;
    localparam int CM = 4;
    localparam int RC = 2;
    localparam int TO = 255;

    logic mclk = 1'b0;
    logic reset = 1'b1;
    logic AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
    logic mem_sel = 1'b0, io_sel = 1'b0, WAIT = 1'b1;
    logic BALE, MEMR, MEMW, IOR, IOW, SA0, XRDYD, dg_oe, da_oe, berr_req;

    isa_cycle_sequencer #(.BALE_CYC(BC), .CMD_MIN(CM), .RECOV_CYC(RC), .TIMEOUT_CYC(TO)) dut (
        .mclk(mclk), .reset(reset), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .mem_sel(mem_sel), .io_sel(io_sel), .WAIT(WAIT),
        .BALE(BALE), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW), .SA0(SA0),
        .XRDYD(XRDYD), .dg_oe(dg_oe), .da_oe(da_oe), .berr_req(berr_req)
    );

    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    // id: 0 MEMR, 1 MEMW, 2 IOR, 3 IOW
    typedef struct {
        int id;
        int sa0;
        int early;
        int wlen;
    } exp_t;
    exp_t q[$];
    bit skip_txn = 1'b0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(string nm, int act, int lo, int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0, last_end = 0, gap = 0, ph = 0, blen = 0, tot = 0, llen = 0, id = -1, nbale = 0;
    bit first = 1'b1, seen, viol, dg_all, dg_any, da_pre, da_done, sk, sa0v;
    logic [3:0] s;
    int nl;

    task automatic finish_txn();
        exp_t e;
        bit wr;
        last_end = cyc;
        ph = 0;
        if (!sk) begin
            if (q.size() == 0) begin
                chk("unexpected_cycle", 1, 0);
            end else begin
                e = q.pop_front();
                chk("strobe_id", id, e.id);
                chk("sa0", int'(sa0v), e.sa0);
                chk("bale_len", blen, BC);
                if (!first) chk_rng("recovery_gap", gap, RC, 100000);
                if (e.early != 0) begin
                    chk("xrdyd_seen_early", int'(seen), 0);
                    chk("early_low_len", tot, CM);
                end else begin
                    chk("xrdyd_seen", int'(seen), 1);
                    if (e.wlen == 0) chk("cmd_len", llen, CM);
                    else chk_rng("wait_len", llen, e.wlen + 2, e.wlen + 4);
                end
                wr = (e.id == 1 || e.id == 3);
                if (wr) begin
                    chk("dg_oe_write", int'(dg_all), 1);
                    chk("da_oe_write", int'(da_pre | da_done), 0);
                end else begin
                    chk("dg_oe_read", int'(dg_any), 0);
                    chk("da_oe_before_done", int'(da_pre), 0);
                    if (e.early == 0) chk("da_oe_done", int'(da_done), 1);
                end
                chk("invariants", int'(viol), 0);
            end
        end
        first = 1'b0;
    endtask

    always @(negedge mclk) begin
        cyc++;
        if (!reset) begin
            ph = 0;
            first = 1'b1;
        end else begin
            s  = ~{IOW, IOR, MEMW, MEMR};
            nl = $countones(s);
            if (nl > 1 || (BALE && nl > 0) || (!XRDYD && nl == 0)) viol = 1'b1;
            case (ph)
                0: begin
                    if (BALE) begin
                        ph = 1; blen = 1; gap = cyc - last_end; viol = 1'b0; tot = 0; llen = 0;
                        seen = 1'b0; dg_all = 1'b1; dg_any = 1'b0; da_pre = 1'b0; da_done = 1'b0;
                        sk = skip_txn; id = -1; nbale++;
                    end else if (nl > 0) begin
                        chk("strobe_without_bale", nl, 0);
                    end
                end
                1: begin
                    if (BALE) begin
                        blen++;
                    end else if (nl == 1) begin
                        ph = 2; tot = 1; sa0v = SA0;
                        for (int k = 0; k < 4; k++) if (s[k]) id = k;
                        if (!XRDYD) viol = 1'b1;
                        dg_all &= dg_oe; dg_any |= dg_oe; da_pre |= da_oe;
                    end else begin
                        viol = 1'b1;
                        finish_txn();
                    end
                end
                default: begin
                    if (nl == 1) begin
                        tot++;
                        if (s != 4'(1 << id)) viol = 1'b1;
                        if (!XRDYD && !seen) begin
                            seen = 1'b1; llen = tot - 1; da_done = da_oe;
                        end
                        dg_all &= dg_oe; dg_any |= dg_oe;
                        if (!seen) da_pre |= da_oe;
                    end else begin
                        finish_txn();
                    end
                end
            endcase
        end
    end

    // ---------------- driver ----------------
    function automatic bit probe(int k);
        case (k)
            0: probe = !(MEMR && MEMW && IOR && IOW);
            1: probe = BALE;
            2: probe = !XRDYD;
            3: probe = MEMR && MEMW && IOR && IOW;
            4: probe = berr_req;
            default: probe = !berr_req;
        endcase
    endfunction

    task automatic wait_for(int k, int budget, string nm, output int n);
        n = 0;
        while (!probe(k) && n < budget) begin
            @(negedge mclk);
            n++;
        end
        if (!probe(k)) chk(nm, 0, 1);
    endtask

    task automatic run_txn(bit mem, bit rd, bit u, bit l, int wlen, bit early, int lag, bit b2b);
        exp_t e;
        int n;
        e.id    = mem ? (rd ? 0 : 1) : (rd ? 2 : 3);
        e.sa0   = (l && !u) ? 1 : 0;
        e.early = early ? 1 : 0;
        e.wlen  = wlen;
        q.push_back(e);
        mem_sel = mem; io_sel = !mem; RW = rd;
        WAIT = (wlen > 0) ? 1'b0 : 1'b1;
        AS = 1'b0;
        repeat (lag) @(negedge mclk);
        UDS = !u; LDS = !l;
        wait_for(1, 60, "bale_timeout", n);
        if (early) begin
            AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
            wait_for(0, 20, "strobe_timeout", n);
        end else begin
            if (wlen > 0) begin
                wait_for(0, 20, "strobe_timeout", n);
                repeat (wlen) @(negedge mclk);
                WAIT = 1'b1;
            end
            wait_for(2, 200, "xrdyd_timeout", n);
            repeat ($urandom_range(0, 2)) @(negedge mclk);
            AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        end
        if (b2b) begin
            @(negedge mclk);
        end else begin
            wait_for(3, 20, "strobe_release_timeout", n);
            mem_sel = 1'b0; io_sel = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge mclk);
        end
    endtask

    initial begin
        int n, b0, v;
        bit ok, xr_low;
        #1 reset = 1'b0;
        repeat (3) @(negedge mclk);
        chk("reset_outputs", int'({BALE, MEMR, MEMW, IOR, IOW, SA0, XRDYD, dg_oe, da_oe, berr_req}),
            int'(10'b0_1111_0_1_0_0_0));
        reset = 1'b1;
        repeat (3) @(negedge mclk);

        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 10, 1'b0);  // memory write, UDS lags AS
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 30, 1'b0, 0, 1'b0);  // memory read stretched by WAIT
        run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);   // IO byte write on LDS
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b1);   // back-to-back pair
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

        // both selects high: must be ignored
        b0 = nbale; ok = 1'b1;
        mem_sel = 1'b1; io_sel = 1'b1; RW = 1'b0; AS = 1'b0; UDS = 1'b0;
        repeat (20) begin
            @(negedge mclk);
            if ({BALE, MEMR, MEMW, IOR, IOW, XRDYD, dg_oe, da_oe} != 8'b0_1111_1_00) ok = 1'b0;
        end
        chk("ignored_bale_count", nbale - b0, 0);
        chk("ignored_outputs_idle", int'(ok), 1);
        AS = 1'b1; UDS = 1'b1; mem_sel = 1'b0; io_sel = 1'b0;
        repeat (3) @(negedge mclk);

        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);   // early AS negation

        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(1, 3);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v[1], v[0],
                    ($urandom_range(0, 1) != 0) ? $urandom_range(6, 40) : 0,
                    1'b0, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
        wait_for(3, 20, "final_release_timeout", n);
        repeat (4) @(negedge mclk);

        // reset while the write strobe is low
        skip_txn = 1'b1;
        mem_sel = 1'b1; io_sel = 1'b0; RW = 1'b0; WAIT = 1'b1; AS = 1'b0; UDS = 1'b0;
        wait_for(0, 40, "reset_txn_strobe_timeout", n);
        #2 reset = 1'b0;
        #1;
        chk("reset_memw", int'(MEMW), 1);
        chk("reset_xrdyd", int'(XRDYD), 1);
        chk("reset_dg_oe", int'(dg_oe), 0);
        chk("reset_bale", int'(BALE), 0);
        AS = 1'b1; UDS = 1'b1; mem_sel = 1'b0;
        repeat (2) @(negedge mclk);
        reset = 1'b1;
        repeat (5) @(negedge mclk);
        skip_txn = 1'b0;

        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);   // clean cycle after reset

`ifdef ISA_WAIT_TIMEOUT_EN
        skip_txn = 1'b1;
        mem_sel = 1'b1; io_sel = 1'b0; RW = 1'b1; WAIT = 1'b0; AS = 1'b0; UDS = 1'b0;
        wait_for(0, 40, "timeout_strobe_timeout", n);
        n = 0; xr_low = 1'b0;
        while (!berr_req && n < 400) begin
            @(negedge mclk);
            n++;
            xr_low |= !XRDYD;
        end
        chk_rng("berr_delay", n, CM + TO - 1, CM + TO + 2);
        chk("berr_xrdyd_stays_high", int'(xr_low), 0);
        AS = 1'b1; UDS = 1'b1;
        wait_for(5, 10, "berr_clear_timeout", n);
        wait_for(3, 10, "berr_strobe_release_timeout", n);
        chk("berr_cleared", int'(berr_req), 0);
        WAIT = 1'b1; mem_sel = 1'b0;
        repeat (5) @(negedge mclk);
        skip_txn = 1'b0;
`else
        chk("berr_tied_low", int'(berr_req), 0);
`endif

        repeat (5) @(negedge mclk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish within 50000 cycles");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isa_cycle_sequencer.md
Name: isa_cycle_sequencer

Overview:
- Downstream stage of the Zorro-II address decode/autoconfig logic on the GBAPII++ card.
- Converts a decoded Amiga bus cycle (AS/UDS/LDS/RW plus mem/io select) into a timed ISA cycle: BALE, MEMR/MEMW/IOR/IOW, SA0.
- Stretches the cycle on ISA WAIT and returns XRDYD to the Amiga side.
- Also drives the DG/DA buffer enables consumed by the top level.

Parameters:
- BALE_CYC, 1: mclk cycles BALE is high before the command strobe.
- CMD_MIN, 4: minimum mclk cycles a command strobe stays asserted.
- RECOV_CYC, 2: mclk cycles all strobes stay inactive after a cycle before the next may start.
- TIMEOUT_CYC, 255: WAIT-low limit in cycles; used only with the optional feature.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- AS  in  1  Amiga address strobe, active-low, asynchronous to mclk.
- UDS  in  1  upper data strobe, active-low, asynchronous.
- LDS  in  1  lower data strobe, active-low, asynchronous.
- RW  in  1  1=read, 0=write.
- mem_sel  in  1  decode: address hits the configured memory window; stable while AS low.
- io_sel  in  1  decode: address hits the configured IO window; stable while AS low.
- WAIT  in  1  ISA ready, active-low = extend cycle; asynchronous.
- BALE  out  1  ISA address latch enable, active-high.
- MEMR  out  1  active-low.
- MEMW  out  1  active-low.
- IOR  out  1  active-low.
- IOW  out  1  active-low.
- SA0  out  1  ISA byte address bit.
- XRDYD  out  1  active-low transfer-done to Amiga side.
- dg_oe  out  1  drive ISA data bus (write cycles).
- da_oe  out  1  drive Amiga data bus (read cycles).
- berr_req  out  1  timeout error request, active-high.

Behaviour:
- Synchronisation: AS, UDS, LDS and WAIT each pass a 2-flop synchroniser; "as_s" etc. below denote the synchronised values.
- Reset values: BALE=0; MEMR=MEMW=IOR=IOW=1; SA0=0; XRDYD=1; dg_oe=0; da_oe=0; berr_req=0; state=IDLE. Reset mid-cycle aborts immediately to these values.
- Start condition: as_s=0 AND (uds_s=0 OR lds_s=0) AND (mem_sel XOR io_sel). If both selects are high, the cycle is ignored and the state stays IDLE. On write cycles the start waits for the data strobe, which may lag AS.
- SA0 is latched at start: 1 if only LDS is low, else 0.
- The command type (mem/io, rd/wr) is latched at start and held for the whole cycle.
- All outputs are registered.
- States:
  - IDLE: on start -> ALE.
  - ALE: BALE=1 for BALE_CYC cycles; dg_oe=1 on writes from this state on -> CMD.
  - CMD: the selected strobe is low. After CMD_MIN cycles -> WAITST if wait_s=0, else -> DONE.
  - WAITST: strobe stays low while wait_s=0; wait_s=1 -> DONE.
  - DONE: strobe stays low; XRDYD=0; da_oe=1 on reads. Held until as_s=1 -> RECOVER.
  - RECOVER: strobes, XRDYD, dg_oe and da_oe all inactive for RECOV_CYC cycles -> IDLE. A start condition present here is deferred, not lost.
- AS negated early (as_s=1 in ALE, CMD or WAITST): the strobe is held until CMD_MIN is satisfied, then -> RECOVER with no XRDYD.
- At most one strobe is low at any time. BALE and any strobe never overlap.
- Latency at defaults with WAIT inactive: start edge -> BALE 1 cycle -> strobe low 4 cycles -> XRDYD low on the 6th edge after start.

Optional Feature:
- Macro: ISA_WAIT_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAITST. When it reaches TIMEOUT_CYC, berr_req=1 and the state goes to DONE without XRDYD. berr_req is held until as_s=1, then the normal RECOVER/IDLE sequence follows.
- Undefined: WAITST waits indefinitely; berr_req is tied 0.

Test Plan:
- Memory write: mem_sel=1, RW=0, AS low, UDS low 10 cycles later, WAIT=1 -> BALE 1 cycle, then MEMW low 4 cycles, XRDYD low, dg_oe=1, SA0=0. AS high -> all strobes high, 2 idle cycles.
- Memory read with wait: mem_sel=1, RW=1, AS/UDS low, WAIT low 30 cycles -> MEMR low throughout the wait, XRDYD stays 1 until 2 cycles after WAIT rises, da_oe=1 in DONE.
- IO byte write on LDS only: io_sel=1, RW=0, LDS=0, UDS=1 -> IOW low, SA0=1, MEMR/MEMW stay 1.
- Back-to-back: second AS falls 1 cycle after the first rises -> next BALE no earlier than 2 cycles after RECOVER entry. Both mem_sel=io_sel=1 -> no outputs change.
- Reset mid-CMD: reset low while MEMW low -> MEMW=1, XRDYD=1, dg_oe=0 immediately (asynchronously).
- ISA_WAIT_TIMEOUT_EN defined: WAIT held low forever -> berr_req=1 after 255 WAITST cycles, XRDYD stays 1. AS high -> berr_req=0, then IDLE.
